// File: rtl/pkt_merge.sv
// Packet-atomic two-source AXI-Stream merger with a single registered output slot.
// Define PKT_MERGE_CTRL_PRIO_EN for strict control priority; otherwise round-robin.
module pkt_merge #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic                              c_s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [31:0]                       data_pkt_cnt,
    output logic [31:0]                       ctrl_pkt_cnt
);

    typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTL} state_t;

    state_t state;
    logic   slot_free;
    logic   pick_data;
    logic   pick_ctl;
    logic   data_acc;
    logic   ctl_acc;

`ifndef PKT_MERGE_CTRL_PRIO_EN
    typedef enum logic {GRANT_DATA, GRANT_CTL} grant_t;
    grant_t last_grant;
`endif

    assign slot_free = !m_axis_tvalid || m_axis_tready;

    // In IDLE the grant depends on the current tvalids, so readies are combinational.
    always_comb begin
        pick_data = 1'b0;
        pick_ctl  = 1'b0;
        case (state)
            IDLE: begin
`ifdef PKT_MERGE_CTRL_PRIO_EN
                pick_ctl  = c_s_axis_tvalid;
                pick_data = s_axis_tvalid && !c_s_axis_tvalid;
`else
                if (s_axis_tvalid && c_s_axis_tvalid) begin
                    pick_data = (last_grant == GRANT_CTL);
                    pick_ctl  = (last_grant == GRANT_DATA);
                end else begin
                    pick_data = s_axis_tvalid;
                    pick_ctl  = c_s_axis_tvalid;
                end
`endif
            end
            FWD_DATA: pick_data = 1'b1;
            FWD_CTL:  pick_ctl  = 1'b1;
            default: begin
                pick_data = 1'b0;
                pick_ctl  = 1'b0;
            end
        endcase
    end

    assign s_axis_tready   = aresetn && slot_free && pick_data;
    assign c_s_axis_tready = aresetn && slot_free && pick_ctl;
    assign data_acc        = s_axis_tvalid && s_axis_tready;
    assign ctl_acc         = c_s_axis_tvalid && c_s_axis_tready;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state         <= IDLE;
`ifndef PKT_MERGE_CTRL_PRIO_EN
            last_grant    <= GRANT_CTL;
`endif
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            data_pkt_cnt  <= '0;
            ctrl_pkt_cnt  <= '0;
        end else if (data_acc) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s_axis_tlast;
            state         <= s_axis_tlast ? IDLE : FWD_DATA;
            if (s_axis_tlast) data_pkt_cnt <= data_pkt_cnt + 32'd1;
`ifndef PKT_MERGE_CTRL_PRIO_EN
            if (state == IDLE) last_grant <= GRANT_DATA;
`endif
        end else if (ctl_acc) begin
            m_axis_tdata  <= c_s_axis_tdata;
            m_axis_tkeep  <= c_s_axis_tkeep;
            m_axis_tuser  <= c_s_axis_tuser;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= c_s_axis_tlast;
            state         <= c_s_axis_tlast ? IDLE : FWD_CTL;
            if (c_s_axis_tlast) ctrl_pkt_cnt <= ctrl_pkt_cnt + 32'd1;
`ifndef PKT_MERGE_CTRL_PRIO_EN
            if (state == IDLE) last_grant <= GRANT_CTL;
`endif
        end else if (slot_free) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
